// File: rtl/arbiter_pkg.sv
// Shared types for the memory bus arbiter: FSM state encoding and burst counter width.
package arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_INSTR,
    ARB_DATA,
    ARB_DRAIN
  } arb_state_t;

  localparam int BURST_CNT_W = 4;

endpackage

// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between fetch and load/store; grant strobes memory the cycle after request,
// responses pass straight through, and requesters hold their level request until their rsp pulse.
module mem_bus_arbiter
  import arbiter_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int MAX_DATA_BURST = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  instr_req_i,
  input  logic                  instr_flush_i,
  input  logic [DATA_WIDTH-1:0] instr_addr_i,
  output logic                  instr_rsp_o,
  output logic [DATA_WIDTH-1:0] instr_data_o,
  input  logic                  data_rd_i,
  input  logic                  data_wr_i,
  input  logic [DATA_WIDTH-1:0] data_addr_i,
  input  logic [DATA_WIDTH-1:0] data_write_i,
  output logic                  data_rsp_o,
  output logic [DATA_WIDTH-1:0] data_read_o,
  output logic                  mem_rd_o,
  output logic                  mem_wr_o,
  output logic [DATA_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_write_o,
  input  logic                  mem_rsp_i,
  input  logic [DATA_WIDTH-1:0] mem_read_i
);

  localparam logic [BURST_CNT_W-1:0] BURST_MAX = BURST_CNT_W'(MAX_DATA_BURST);

  arb_state_t             state;
  arb_state_t             state_nxt;
  logic [BURST_CNT_W-1:0] burst_cnt;
  logic                   data_req;
  logic                   instr_elig;
  logic                   grant_instr;
  logic                   grant_data;

  assign data_req   = data_rd_i | data_wr_i;
  // A flushing fetch is never eligible, even if its request level is still high.
  assign instr_elig = instr_req_i & ~instr_flush_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ARB_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    grant_instr = 1'b0;
    grant_data  = 1'b0;
    instr_rsp_o = 1'b0;
    data_rsp_o  = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (instr_elig && (burst_cnt == BURST_MAX || !data_req)) begin
          grant_instr = 1'b1;
          state_nxt   = ARB_INSTR;
        end else if (data_req) begin
          grant_data = 1'b1;
          state_nxt  = ARB_DATA;
        end
      end
      ARB_INSTR: begin
        if (mem_rsp_i) begin
          instr_rsp_o = ~instr_flush_i;
          state_nxt   = ARB_IDLE;
        end else if (instr_flush_i) begin
          state_nxt = ARB_DRAIN;
        end
      end
      ARB_DATA: begin
        if (mem_rsp_i) begin
          data_rsp_o = 1'b1;
          state_nxt  = ARB_IDLE;
        end
      end
      ARB_DRAIN: begin
        if (mem_rsp_i) begin
          state_nxt = ARB_IDLE;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  assign instr_data_o = instr_rsp_o ? mem_read_i : '0;
  assign data_read_o  = data_rsp_o  ? mem_read_i : '0;

  // Strobes stay up through a drain: the memory cannot abort an issued read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_rd_o    <= 1'b0;
      mem_wr_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_write_o <= '0;
    end else if (grant_instr) begin
      mem_rd_o    <= 1'b1;
      mem_wr_o    <= 1'b0;
      mem_addr_o  <= instr_addr_i;
      mem_write_o <= '0;
    end else if (grant_data) begin
      mem_rd_o    <= ~data_wr_i;
      mem_wr_o    <= data_wr_i;
      mem_addr_o  <= data_addr_i;
      mem_write_o <= data_write_i;
    end else if (state != ARB_IDLE && mem_rsp_i) begin
      mem_rd_o <= 1'b0;
      mem_wr_o <= 1'b0;
    end
  end

  // Counts data grants that overtook a waiting fetch; reaching the limit hands the next slot to fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_cnt <= '0;
    end else if (grant_instr || !instr_req_i) begin
      burst_cnt <= '0;
    end else if (grant_data && burst_cnt != BURST_MAX) begin
      burst_cnt <= burst_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized fetch/load/store traffic against a transaction-level arbitration model with response scoreboards.
module tb_mem_bus_arbiter;

  localparam int DW   = 32;
  localparam int MAXB = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          instr_req_i = 1'b0, instr_flush_i = 1'b0;
  logic [DW-1:0] instr_addr_i = '0;
  logic          instr_rsp_o;
  logic [DW-1:0] instr_data_o;
  logic          data_rd_i = 1'b0, data_wr_i = 1'b0;
  logic [DW-1:0] data_addr_i = '0, data_write_i = '0;
  logic          data_rsp_o;
  logic [DW-1:0] data_read_o;
  logic          mem_rd_o, mem_wr_o;
  logic [DW-1:0] mem_addr_o, mem_write_o;
  logic          mem_rsp_i = 1'b0;
  logic [DW-1:0] mem_read_i = '0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.DATA_WIDTH(DW), .MAX_DATA_BURST(MAXB)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_req_i(instr_req_i), .instr_flush_i(instr_flush_i), .instr_addr_i(instr_addr_i),
    .instr_rsp_o(instr_rsp_o), .instr_data_o(instr_data_o),
    .data_rd_i(data_rd_i), .data_wr_i(data_wr_i), .data_addr_i(data_addr_i),
    .data_write_i(data_write_i), .data_rsp_o(data_rsp_o), .data_read_o(data_read_o),
    .mem_rd_o(mem_rd_o), .mem_wr_o(mem_wr_o), .mem_addr_o(mem_addr_o),
    .mem_write_o(mem_write_o), .mem_rsp_i(mem_rsp_i), .mem_read_i(mem_read_i)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  // ---------------- reference model (transaction level) ----------------
  typedef enum {OWN_INSTR, OWN_DATA, OWN_DRAIN} own_t;
  typedef struct packed { logic wr; logic [31:0] data; } dexp_t;

  logic        m_busy = 1'b0;
  own_t        m_owner = OWN_INSTR;
  logic        m_wr = 1'b0;
  logic [31:0] m_addr = '0, m_wdata = '0;
  int          m_wait = 0;          // data grants taken while the current fetch waited
  logic [31:0] ref_dmem [logic [31:0]];
  logic [31:0] exp_iq [$];
  dexp_t       exp_dq [$];
  logic        g_instr, g_data, fetch_ok, dreq;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_busy = 1'b0;
      m_wait = 0;
      exp_iq.delete();
      exp_dq.delete();
    end else begin
      g_instr = 1'b0;
      g_data  = 1'b0;
      if (m_busy) begin
        if (mem_rsp_i) begin
          if (m_owner == OWN_INSTR && instr_flush_i && exp_iq.size() > 0) void'(exp_iq.pop_front());
          m_busy = 1'b0;
        end else if (m_owner == OWN_INSTR && instr_flush_i) begin
          m_owner = OWN_DRAIN;
          if (exp_iq.size() > 0) void'(exp_iq.pop_front());
        end
      end else begin
        fetch_ok = instr_req_i && !instr_flush_i;
        dreq     = data_rd_i || data_wr_i;
        if (fetch_ok && (m_wait >= MAXB || !dreq)) begin
          g_instr = 1'b1;
          m_busy  = 1'b1; m_owner = OWN_INSTR; m_wr = 1'b0;
          m_addr  = instr_addr_i; m_wdata = '0;
          exp_iq.push_back(init_word(instr_addr_i));
        end else if (dreq) begin
          g_data  = 1'b1;
          m_busy  = 1'b1; m_owner = OWN_DATA; m_wr = data_wr_i;
          m_addr  = data_addr_i; m_wdata = data_wr_i ? data_write_i : '0;
          if (data_wr_i) begin
            ref_dmem[data_addr_i] = data_write_i;
            exp_dq.push_back('{wr: 1'b1, data: 32'h0});
          end else begin
            exp_dq.push_back('{wr: 1'b0,
              data: ref_dmem.exists(data_addr_i) ? ref_dmem[data_addr_i] : init_word(data_addr_i)});
          end
        end
      end
      if (g_instr || !instr_req_i) m_wait = 0;
      else if (g_data) m_wait = (m_wait < MAXB) ? m_wait + 1 : MAXB;
    end
  end

  // ---------------- monitor ----------------
  logic  irsp_seen = 1'b0, drsp_seen = 1'b0;
  logic  exp_rd, exp_wr, exp_ir, exp_dr;
  dexp_t de;

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      assert (!(data_rd_i && data_wr_i)) else $error("illegal simultaneous load and store request");
      exp_rd = m_busy && !(m_owner == OWN_DATA && m_wr);
      exp_wr = m_busy && m_owner == OWN_DATA && m_wr;
      check("strobes", {30'b0, mem_rd_o, mem_wr_o}, {30'b0, exp_rd, exp_wr});
      if (m_busy) check("mem_addr", mem_addr_o, m_addr);
      if (exp_wr) check("mem_write", mem_write_o, m_wdata);
      exp_ir = m_busy && m_owner == OWN_INSTR && mem_rsp_i && !instr_flush_i;
      exp_dr = m_busy && m_owner == OWN_DATA && mem_rsp_i;
      if (mem_rsp_i || instr_rsp_o || data_rsp_o) begin
        check("instr_rsp", instr_rsp_o, exp_ir);
        check("data_rsp", data_rsp_o, exp_dr);
      end
      if (instr_rsp_o) begin
        if (exp_iq.size() == 0) check("instr_rsp_spurious", instr_rsp_o, 1'b0);
        else check("instr_data", instr_data_o, exp_iq.pop_front());
      end
      if (data_rsp_o) begin
        if (exp_dq.size() == 0) check("data_rsp_spurious", data_rsp_o, 1'b0);
        else begin
          de = exp_dq.pop_front();
          if (!de.wr) check("data_read", data_read_o, de.data);
        end
      end
      if (mem_rsp_i && !exp_ir) check("instr_data_gate", instr_data_o, 32'h0);
      if (mem_rsp_i && !exp_dr) check("data_read_gate", data_read_o, 32'h0);
    end
    irsp_seen = rst_n && instr_rsp_o;
    drsp_seen = rst_n && data_rsp_o;
  end

  // ---------------- stimulus: requesters and memory ----------------
  logic        f_active = 1'b0, d_active = 1'b0, stop_new = 1'b0, slave_en = 1'b1;
  int          f_gap = 0, d_gap = 0, s_delay = 0;
  logic        s_serving = 1'b0, s_pulse = 1'b0;
  logic [31:0] smem [logic [31:0]];

  task automatic step();
    instr_flush_i = 1'b0;
    if (f_active) begin
      if (irsp_seen) begin
        f_active = 1'b0; f_gap = $urandom_range(0, 2);
      end else if ($urandom_range(0, 15) == 0) begin
        instr_flush_i = 1'b1; f_active = 1'b0; f_gap = $urandom_range(0, 2);
      end
    end else if (!instr_flush_i) begin
      instr_req_i = 1'b0;
    end
    if (!f_active && !instr_flush_i) begin
      if (f_gap > 0) begin
        f_gap--; instr_req_i = 1'b0;
      end else if (!stop_new) begin
        f_active = 1'b1; instr_req_i = 1'b1;
        instr_addr_i = 32'h1000_0000 | ($urandom_range(0, 255) << 2);
      end else instr_req_i = 1'b0;
    end

    if (d_active && drsp_seen) begin
      d_active = 1'b0;
      d_gap = ($urandom_range(0, 9) < 7) ? 0 : $urandom_range(1, 4);
    end
    if (!d_active) begin
      data_rd_i = 1'b0; data_wr_i = 1'b0;
      if (d_gap > 0) d_gap--;
      else if (!stop_new) begin
        d_active = 1'b1;
        if ($urandom_range(0, 1) == 1) data_wr_i = 1'b1; else data_rd_i = 1'b1;
        data_addr_i  = 32'h2000_0000 | ($urandom_range(0, 15) << 2);
        data_write_i = $urandom;
      end
    end

    if (s_pulse) begin
      mem_rsp_i = 1'b0; s_pulse = 1'b0; mem_read_i = $urandom;
    end else if (slave_en) begin
      if (!s_serving && (mem_rd_o || mem_wr_o)) begin
        s_serving = 1'b1; s_delay = $urandom_range(0, 3);
      end
      if (s_serving) begin
        if (s_delay == 0) begin
          mem_rsp_i = 1'b1; s_pulse = 1'b1; s_serving = 1'b0;
          if (mem_wr_o) begin
            smem[mem_addr_o] = mem_write_o; mem_read_i = $urandom;
          end else begin
            mem_read_i = smem.exists(mem_addr_o) ? smem[mem_addr_o] : init_word(mem_addr_o);
          end
        end else s_delay--;
      end else if ($urandom_range(0, 19) == 0) begin
        mem_rsp_i = 1'b1; s_pulse = 1'b1; mem_read_i = $urandom;
      end
    end
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      step();
    end
  endtask

  task automatic drain();
    stop_new = 1'b1;
    for (int i = 0; i < 400 && (f_active || d_active || s_serving || s_pulse || m_busy); i++) begin
      @(posedge clk); #1;
      step();
    end
    run(3);
    check("drain_idle", {28'b0, f_active, d_active, mem_rd_o, mem_wr_o}, 32'h0);
  endtask

  initial begin
    #2;
    check("rst_mem_rd", mem_rd_o, 1'b0);
    check("rst_mem_wr", mem_wr_o, 1'b0);
    check("rst_mem_addr", mem_addr_o, 32'h0);
    check("rst_mem_write", mem_write_o, 32'h0);
    check("rst_instr_rsp", instr_rsp_o, 1'b0);
    check("rst_data_rsp", data_rsp_o, 1'b0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    run(2500);
    drain();

    // Abandon a store in flight via async reset.
    slave_en = 1'b0;
    @(posedge clk); #1;
    data_wr_i = 1'b1; data_addr_i = 32'h2000_0400; data_write_i = 32'hCAFE_F00D;
    for (int i = 0; i < 10 && !mem_wr_o; i++) begin
      @(posedge clk); #1;
    end
    check("pre_reset_wr", mem_wr_o, 1'b1);
    #2 rst_n = 1'b0;
    mem_rsp_i = 1'b1;
    #1;
    check("arst_mem_rd", mem_rd_o, 1'b0);
    check("arst_mem_wr", mem_wr_o, 1'b0);
    check("arst_mem_addr", mem_addr_o, 32'h0);
    check("arst_mem_write", mem_write_o, 32'h0);
    check("arst_data_rsp", data_rsp_o, 1'b0);
    check("arst_instr_rsp", instr_rsp_o, 1'b0);
    data_wr_i = 1'b0; mem_rsp_i = 1'b0;
    s_serving = 1'b0; s_pulse = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    slave_en = 1'b1; stop_new = 1'b0;

    run(1500);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Shares one memory port between the core's instruction-fetch bus and its load/store data bus.
- Sits between the core (instr_*/data_mem_* buses) and the single SoC memory/interconnect port.
- Grants one transaction at a time and holds address and data stable until the memory responds.
- Data has priority, with a bounded-starvation guarantee for fetch.
- Honours fetch flush by draining, but never forwarding, an already-issued fetch.

Parameters:
DATA_WIDTH, 32, width of address, write-data and read-data buses.
MAX_DATA_BURST, 4, max consecutive data grants while a fetch request waits; range 1..15.

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
instr_req_i  input  1  fetch request, level, held until instr_rsp_o or flush
instr_flush_i  input  1  cancel outstanding/pending fetch
instr_addr_i  input  DATA_WIDTH  fetch address
instr_rsp_o  output  1  one-cycle fetch completion pulse
instr_data_o  output  DATA_WIDTH  fetched word, valid with instr_rsp_o
data_rd_i  input  1  load request, level, held until data_rsp_o
data_wr_i  input  1  store request, level, held until data_rsp_o
data_addr_i  input  DATA_WIDTH  load/store address
data_write_i  input  DATA_WIDTH  store data
data_rsp_o  output  1  one-cycle load/store completion pulse
data_read_o  output  DATA_WIDTH  load data, valid with data_rsp_o
mem_rd_o  output  1  memory read strobe, held until mem_rsp_i
mem_wr_o  output  1  memory write strobe, held until mem_rsp_i
mem_addr_o  output  DATA_WIDTH  registered address
mem_write_o  output  DATA_WIDTH  registered store data
mem_rsp_i  input  1  one-cycle memory completion pulse
mem_read_i  input  DATA_WIDTH  memory read data, valid with mem_rsp_i

Behaviour:
- Reset (async, rst_n=0):
  - state ARB_IDLE, burst counter 0.
  - mem_rd_o, mem_wr_o, mem_addr_o, mem_write_o = 0.
  - instr_rsp_o and data_rsp_o forced 0.
  - A transaction in flight at reset is abandoned; memory shares rst_n.
- FSM states: ARB_IDLE, ARB_INSTR, ARB_DATA, ARB_DRAIN.
- ARB_IDLE:
  - Evaluate requests each cycle.
  - Winner is registered: at the next edge the state changes, mem_* are loaded, and the strobe is asserted.
  - Minimum latency is request at cycle N, strobe at N+1.
- Priority:
  - Data wins unless instr_req_i=1 and burst counter == MAX_DATA_BURST; then fetch wins.
  - Counter increments on each data grant while instr_req_i=1, saturates at MAX_DATA_BURST.
  - Counter clears on any fetch grant, or in any cycle with instr_req_i=0.
- Read/write select: data_rd_i and data_wr_i both high is illegal. The write wins (mem_wr_o=1) and the bench asserts on it.
- ARB_INSTR / ARB_DATA:
  - Strobe and mem_addr_o/mem_write_o are held constant.
  - On mem_rsp_i, the owner's rsp_o equals mem_rsp_i in the same cycle (combinational).
  - Read data passes through combinationally (instr_data_o = data_read_o = mem_read_i, gated to 0 when not responding).
  - At the following edge: strobes deassert, state goes to ARB_IDLE.
  - Back-to-back turnaround is rsp at cycle M, next strobe earliest at M+2.
- Flush:
  - instr_flush_i in ARB_INSTR without mem_rsp_i: go to ARB_DRAIN; mem_rd_o stays high, since the memory cannot be aborted.
  - Flush coincident with mem_rsp_i in ARB_INSTR: instr_rsp_o suppressed, go to ARB_IDLE.
  - Flush in ARB_IDLE: the fetch is not eligible for grant that cycle; data may still be granted.
  - Flush in ARB_DATA or ARB_DRAIN has no effect.
- ARB_DRAIN: wait for mem_rsp_i with no response forwarded, then go to ARB_IDLE. A new fetch (new address) is granted only after that.
- mem_rsp_i in ARB_IDLE is spurious: ignored, no rsp_o.
- Requester changing address mid-transaction has no effect; the registered copy is used.

Decomposition:
- Package arbiter_pkg:
  - typedef enum logic [1:0] arb_state_t {ARB_IDLE, ARB_INSTR, ARB_DATA, ARB_DRAIN}.
  - localparam BURST_CNT_W = 4.
- Single module; no sub-module. The priority/starvation logic is under 30 lines and stays inline.

Test Plan:
- Single load: data_rd_i=1, addr 0x100, memory responds 2 cycles after strobe with 0xDEADBEEF -> mem_rd_o from N+1, data_rsp_o one pulse, data_read_o=0xDEADBEEF, instr_rsp_o=0.
- Simultaneous fetch 0x0 and store 0x200/0x12345678 -> mem_wr_o first with addr 0x200/data 0x12345678; fetch granted after its rsp, with the strobe at rsp cycle+2.
- Starvation bound, MAX_DATA_BURST=4, fetch held and data requesting continuously -> exactly 4 data grants, then 1 fetch grant, then counter 0.
- Flush mid-fetch: fetch 0x40 granted, flush before mem_rsp_i -> mem_rd_o held to rsp, instr_rsp_o never pulses, next fetch 0x80 strobed only after drain.
- Flush coincident with mem_rsp_i -> instr_rsp_o=0, state IDLE next cycle.
- rst_n low while ARB_DATA with mem_wr_o=1 -> all mem_* and rsp outputs 0 immediately (async); after release, IDLE and counter 0.
